// File: rtl/conv_requant_pack_pkg.sv
// Shared types and constants for the conv_requant_pack slice.
// Holds the FSM state enum and the int8 saturation helper.
package conv_requant_pkg;

    localparam int LANES  = 8;
    localparam int ACC_W  = 32;
    localparam int PROD_W = 49;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    function automatic logic [7:0] sat_int8(input logic signed [PROD_W:0] v);
        logic [7:0] r;
        if (v > 50'sd127) begin
            r = 8'h7f;
        end else if (v < -50'sd128) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_requant_pack_if.sv
// Control, parameter, accumulator and output streams of conv_requant_pack.
// The block itself connects through the slave modport.
interface conv_requant_pack_if;
    import conv_requant_pkg::*;

    logic                   start;
    logic [15:0]            Out_Channel;
    logic [31:0]            Pixel_Count;
    logic [4:0]             Shift;
    logic [31:0]            pData;
    logic                   pValid;
    logic                   pReady;
    logic [LANES*ACC_W-1:0] sData;
    logic                   sValid;
    logic                   sReady;
    logic [63:0]            mData;
    logic                   mValid;
    logic                   mReady;
    logic                   mLast;
    logic                   busy;
    logic                   done;

    modport slave (
        input  start, Out_Channel, Pixel_Count, Shift,
        input  pData, pValid, sData, sValid, mReady,
        output pReady, sReady, mData, mValid, mLast, busy, done
    );

    modport master (
        output start, Out_Channel, Pixel_Count, Shift,
        output pData, pValid, sData, sValid, mReady,
        input  pReady, sReady, mData, mValid, mLast, busy, done
    );

endinterface

// File: rtl/conv_requant_pack_requant_lane.sv
// One lane of the requant datapath: S1 multiply, S2 round/shift/bias/sat.
// Both stages hold whenever en is low.
module requant_lane
    import conv_requant_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic [15:0]             scale_i,
    input  logic signed [7:0]       bias_i,
    input  logic [4:0]              shift_i,
    output logic [7:0]              q_o
);

    logic signed [PROD_W-1:0] prod_d, prod_q;
    logic signed [PROD_W-1:0] rnd, rsh;
    logic signed [PROD_W:0]   y;
    logic signed [7:0]        bias_d, bias_q;
    logic [7:0]               q_d, q_q;

    always_comb begin
        prod_d = prod_q;
        bias_d = bias_q;
        q_d    = q_q;
        rnd = (shift_i == 5'd0) ? '0 : (PROD_W'(1) <<< (shift_i - 5'd1));
        rsh = (prod_q + rnd) >>> shift_i;
        y   = (PROD_W+1)'(rsh) + (PROD_W+1)'(bias_q);
        if (en) begin
            // scale is unsigned, so widen with a zero sign bit first
            prod_d = PROD_W'(acc_i) * PROD_W'($signed({1'b0, scale_i}));
            bias_d = bias_i;
            q_d    = sat_int8(y);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            bias_q <= '0;
            q_q    <= '0;
        end else begin
            prod_q <= prod_d;
            bias_q <= bias_d;
            q_q    <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/conv_requant_pack.sv
// Requantizes 8 accumulator lanes to packed int8 with per-channel params.
// FSM IDLE->LOAD->RUN, banked param RAM, 3-stage stallable pipeline.
module conv_requant_pack
    import conv_requant_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int ACC_W  = 32,
    parameter int MAX_CH = 512
) (
    input logic          clk,
    input logic          reset,
    conv_requant_pack_if.slave bus
);

    localparam int DEPTH = MAX_CH / LANES;
    localparam int AW    = $clog2(DEPTH);

    state_t      state_d, state_q;
    logic [15:0] oc_d, oc_q;
    logic [31:0] pc_d, pc_q;
    logic [4:0]  shift_d, shift_q;
    logic [15:0] ld_d, ld_q;
    logic [12:0] grp_d, grp_q;
    logic [31:0] pix_d, pix_q;
    logic        lacc_d, lacc_q;
    logic        v0_d, v0_q, v1_d, v1_q, v2_d, v2_q;
    logic        l0_d, l0_q, l1_d, l1_q, l2_d, l2_q;
    logic        done_d, done_q;

    logic [23:0]      pram   [LANES][DEPTH];
    logic [ACC_W-1:0] acc0_q [LANES];
    logic [23:0]      prm0_q [LANES];
    logic [63:0]      mdata;

    logic        en, s_rdy, sfire, pfire, lfire, in_last, legal;
    logic [12:0] ngrp;
    logic        unused_pdata;

    assign unused_pdata = ^bus.pData[7:0];

    always_comb begin
        en      = !v2_q || bus.mReady;
        ngrp    = oc_q[15:3];
        in_last = (grp_q == ngrp - 13'd1) && (pix_q == pc_q - 32'd1);
        s_rdy   = (state_q == RUN) && en && !lacc_q;
        sfire   = s_rdy && bus.sValid;
        pfire   = (state_q == LOAD) && bus.pValid;
        lfire   = v2_q && l2_q && bus.mReady;
        legal   = bus.start && (bus.Out_Channel != 16'd0) &&
                  (bus.Out_Channel[2:0] == 3'd0) &&
                  (bus.Pixel_Count != 32'd0);
    end

    always_comb begin
        state_d = state_q;
        oc_d    = oc_q;
        pc_d    = pc_q;
        shift_d = shift_q;
        ld_d    = ld_q;
        grp_d   = grp_q;
        pix_d   = pix_q;
        lacc_d  = lacc_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (legal) begin
                    state_d = LOAD;
                    oc_d    = bus.Out_Channel;
                    pc_d    = bus.Pixel_Count;
                    shift_d = bus.Shift;
                    ld_d    = '0;
                    grp_d   = '0;
                    pix_d   = '0;
                    lacc_d  = 1'b0;
                end
            end
            LOAD: begin
                if (pfire) begin
                    ld_d = ld_q + 16'd1;
                    if (ld_q == oc_q - 16'd1) state_d = RUN;
                end
            end
            RUN: begin
                if (sfire) begin
                    if (grp_q == ngrp - 13'd1) begin
                        grp_d = '0;
                        pix_d = pix_q + 32'd1;
                    end else begin
                        grp_d = grp_q + 13'd1;
                    end
                    if (in_last) lacc_d = 1'b1;
                end
                if (lfire) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        v0_d = v0_q;
        v1_d = v1_q;
        v2_d = v2_q;
        l0_d = l0_q;
        l1_d = l1_q;
        l2_d = l2_q;
        if (en) begin
            v0_d = sfire;
            l0_d = sfire && in_last;
            v1_d = v0_q;
            l1_d = l0_q;
            v2_d = v1_q;
            l2_d = l1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            oc_q    <= '0;
            pc_q    <= '0;
            shift_q <= '0;
            ld_q    <= '0;
            grp_q   <= '0;
            pix_q   <= '0;
            lacc_q  <= 1'b0;
            done_q  <= 1'b0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            l0_q    <= 1'b0;
            l1_q    <= 1'b0;
            l2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            oc_q    <= oc_d;
            pc_q    <= pc_d;
            shift_q <= shift_d;
            ld_q    <= ld_d;
            grp_q   <= grp_d;
            pix_q   <= pix_d;
            lacc_q  <= lacc_d;
            done_q  <= done_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
        end
    end

    // Param RAM keeps its contents across reset; word k -> bank k%8, row k/8
    always_ff @(posedge clk) begin
        if (pfire && !reset) begin
            pram[ld_q[2:0]][ld_q[AW+2:3]] <= bus.pData[31:8];
        end
    end

    // S0: capture the beat together with the registered param read
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                acc0_q[i] <= bus.sData[ACC_W*i +: ACC_W];
                prm0_q[i] <= pram[i][grp_q[AW-1:0]];
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        requant_lane u_lane (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .acc_i   (acc0_q[i]),
            .scale_i (prm0_q[i][23:8]),
            .bias_i  (prm0_q[i][7:0]),
            .shift_i (shift_q),
            .q_o     (mdata[8*i +: 8])
        );
    end

    assign bus.pReady = (state_q == LOAD);
    assign bus.sReady = s_rdy;
    assign bus.mData  = mdata;
    assign bus.mValid = v2_q;
    assign bus.mLast  = l2_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;

endmodule

// File: tb/tb_conv_requant_pack.sv
// Directed bench for conv_requant_pack: one task per scenario,
// hand-computed expected beats, inline comparisons.
module tb_conv_requant_pack;

    logic clk = 1'b0;
    logic reset;

    conv_requant_pack_if bus ();

    conv_requant_pack #(
        .LANES  (8),
        .ACC_W  (32),
        .MAX_CH (512)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0]  scl       [16];
    logic [7:0]   bia       [16];
    logic [255:0] in_beats  [16];
    logic [63:0]  exp_beats [16];
    logic [15:0]  bp_pat;

    task automatic do_reset();
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.Out_Channel = '0;
        bus.Pixel_Count = '0;
        bus.Shift       = '0;
        bus.pData       = '0;
        bus.pValid      = 1'b0;
        bus.sData       = '0;
        bus.sValid      = 1'b0;
        bus.mReady      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.sReady !== 1'b0) begin
            errors++; $display("FAIL reset_sReady: got %b want 0", bus.sReady);
        end
        checks++;
        if (bus.pReady !== 1'b0) begin
            errors++; $display("FAIL reset_pReady: got %b want 0", bus.pReady);
        end
        checks++;
        if (bus.mValid !== 1'b0 || bus.mLast !== 1'b0) begin
            errors++;
            $display("FAIL reset_mValid_mLast: got %b%b want 00",
                     bus.mValid, bus.mLast);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done: got %b%b want 00", bus.busy, bus.done);
        end
        checks++;
        if (bus.mData !== 64'h0) begin
            errors++; $display("FAIL reset_mData: got %h want 0", bus.mData);
        end
    endtask

    // Called at posedge+1; leaves the block in LOAD.
    task automatic start_layer(input logic [15:0] oc, input logic [31:0] pc,
                               input logic [4:0] sh);
        bus.start       = 1'b1;
        bus.Out_Channel = oc;
        bus.Pixel_Count = pc;
        bus.Shift       = sh;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.pReady !== 1'b1) begin
            errors++;
            $display("FAIL start_load: got busy=%b pReady=%b want 1 1",
                     bus.busy, bus.pReady);
        end
    endtask

    task automatic load_params(input int n);
        for (int k = 0; k < n; k++) begin
            bus.pData  = {scl[k], bia[k], 8'h00};
            bus.pValid = 1'b1;
            if (bus.pReady !== 1'b1) begin
                errors++; checks++;
                $display("FAIL load_pReady: word %0d got %b want 1", k, bus.pReady);
            end
            @(posedge clk);
            #1;
        end
        bus.pValid = 1'b0;
        checks++;
        if (bus.pReady !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL load_to_run: got pReady=%b busy=%b want 0 1",
                     bus.pReady, bus.busy);
        end
    endtask

    // Streams in_beats[0..nb-1] and checks outputs against exp_beats.
    task automatic run_layer(input int nb, input bit bp);
        fork
            begin : feeder
                int b = 0;
                int fc = 0;
                logic hs;
                #1;
                bus.sValid = 1'b1;
                bus.sData  = in_beats[0];
                while (b < nb && fc < 2000) begin
                    hs = bus.sReady;
                    @(posedge clk);
                    #2;
                    fc++;
                    if (hs) begin
                        b++;
                        if (b < nb) bus.sData = in_beats[b];
                        else bus.sValid = 1'b0;
                    end
                end
                bus.sValid = 1'b0;
                if (b < nb) begin
                    errors++; checks++;
                    $display("FAIL feed_timeout: got %0d beats want %0d", b, nb);
                end
            end
            begin : collector
                int oi = 0;
                int cyc = 0;
                bit stall = 1'b0;
                logic [63:0] held = '0;
                while (oi < nb && cyc < 3000) begin
                    bus.mReady = bp ? bp_pat[cyc % 16] : 1'b1;
                    if (stall) begin
                        checks++;
                        if (bus.mData !== held || bus.mValid !== 1'b1) begin
                            errors++;
                            $display("FAIL stall_stable: got %h v=%b want %h v=1",
                                     bus.mData, bus.mValid, held);
                        end
                        stall = 1'b0;
                    end
                    if (bus.mValid === 1'b1) begin
                        if (bus.mReady) begin
                            checks++;
                            if (bus.mData !== exp_beats[oi]) begin
                                errors++;
                                $display("FAIL beat_data[%0d]: got %h want %h",
                                         oi, bus.mData, exp_beats[oi]);
                            end
                            checks++;
                            if (bus.mLast !== (oi == nb - 1)) begin
                                errors++;
                                $display("FAIL beat_last[%0d]: got %b want %b",
                                         oi, bus.mLast, (oi == nb - 1));
                            end
                            oi++;
                        end else begin
                            stall = 1'b1;
                            held  = bus.mData;
                        end
                    end
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                bus.mReady = 1'b1;
                if (oi < nb) begin
                    errors++; checks++;
                    $display("FAIL out_timeout: got %0d beats want %0d", oi, nb);
                end else begin
                    checks++;
                    if (bus.done !== 1'b1 || bus.busy !== 1'b0 ||
                        bus.mValid !== 1'b0) begin
                        errors++;
                        $display("FAIL done_pulse: got done=%b busy=%b mValid=%b want 1 0 0",
                                 bus.done, bus.busy, bus.mValid);
                    end
                    @(posedge clk);
                    #1;
                    checks++;
                    if (bus.done !== 1'b0) begin
                        errors++; $display("FAIL done_width: got %b want 0", bus.done);
                    end
                end
            end
        join
    endtask

    task automatic test_basic();
        for (int k = 0; k < 16; k++) begin
            scl[k] = 16'd256;
            bia[k] = 8'h00;
        end
        for (int b = 0; b < 4; b++) begin
            in_beats[b]  = {8{32'd100}};
            exp_beats[b] = 64'h6464646464646464;
        end
        start_layer(16'd16, 32'd2, 5'd8);
        load_params(16);
        run_layer(4, 1'b0);
    endtask

    task automatic test_round_sat();
        for (int k = 0; k < 8; k++) begin
            scl[k] = 16'd1;
            bia[k] = 8'hFD;
        end
        in_beats[0]  = {8{32'd40}};
        exp_beats[0] = 64'h0000000000000000;
        in_beats[1]  = {8{32'd10000}};
        exp_beats[1] = 64'h7F7F7F7F7F7F7F7F;
        in_beats[2]  = {8{32'hFFFFD8F0}};
        exp_beats[2] = 64'h8080808080808080;
        start_layer(16'd8, 32'd3, 5'd4);
        load_params(8);
        run_layer(3, 1'b0);
    endtask

    task automatic test_mapping();
        for (int k = 0; k < 16; k++) begin
            scl[k] = 16'd1;
            bia[k] = 8'(k);
        end
        in_beats[0]  = '0;
        in_beats[1]  = '0;
        exp_beats[0] = 64'h0706050403020100;
        exp_beats[1] = 64'h0F0E0D0C0B0A0908;
        start_layer(16'd16, 32'd1, 5'd0);
        load_params(16);
        run_layer(2, 1'b0);
    endtask

    // acc a -> (2a + 1) >>> 1 = a, plus bias 1 -> a + 1
    task automatic test_backpressure();
        for (int k = 0; k < 16; k++) begin
            scl[k] = 16'd2;
            bia[k] = 8'h01;
        end
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                in_beats[b][32*i +: 32] = 32'(b * 8 + i - 20);
                exp_beats[b][8*i +: 8]  = 8'(b * 8 + i - 19);
            end
        end
        bp_pat = 16'b1001_0110_0011_1001;
        start_layer(16'd16, 32'd4, 5'd1);
        load_params(16);
        run_layer(8, 1'b1);
    endtask

    task automatic test_illegal();
        logic [15:0] ocs [3];
        logic [31:0] pcs [3];
        ocs[0] = 16'd12; pcs[0] = 32'd4;
        ocs[1] = 16'd16; pcs[1] = 32'd0;
        ocs[2] = 16'd0;  pcs[2] = 32'd4;
        for (int t = 0; t < 3; t++) begin
            bus.start       = 1'b1;
            bus.Out_Channel = ocs[t];
            bus.Pixel_Count = pcs[t];
            bus.Shift       = 5'd0;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            checks++;
            if (bus.busy !== 1'b0 || bus.pReady !== 1'b0) begin
                errors++;
                $display("FAIL illegal_start[%0d]: got busy=%b pReady=%b want 0 0",
                         t, bus.busy, bus.pReady);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL illegal_hold[%0d]: got busy=%b want 0", t, bus.busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 8; k++) begin
            scl[k] = 16'd1;
            bia[k] = 8'h00;
        end
        start_layer(16'd8, 32'd4, 5'd0);
        load_params(8);
        bus.sValid = 1'b1;
        bus.sData  = {8{32'd5}};
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        bus.sValid = 1'b0;
        checks++;
        if (bus.mValid !== 1'b0 || bus.mLast !== 1'b0 || bus.mData !== 64'h0) begin
            errors++;
            $display("FAIL midreset_out: got v=%b l=%b d=%h want 0 0 0",
                     bus.mValid, bus.mLast, bus.mData);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.sReady !== 1'b0 ||
            bus.pReady !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctl: got busy=%b sR=%b pR=%b done=%b want 0 0 0 0",
                     bus.busy, bus.sReady, bus.pReady, bus.done);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        // fresh layer: scale 3, bias -1
        for (int k = 0; k < 8; k++) begin
            scl[k] = 16'd3;
            bia[k] = 8'hFF;
        end
        for (int i = 0; i < 8; i++) begin
            in_beats[0][32*i +: 32] = 32'(i + 5);
            exp_beats[0][8*i +: 8]  = 8'(3 * i + 14);
            in_beats[1][32*i +: 32] = 32'(-(i + 1));
            exp_beats[1][8*i +: 8]  = 8'(-3 * i - 4);
        end
        start_layer(16'd8, 32'd2, 5'd0);
        load_params(8);
        run_layer(2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_sat();
        test_mapping();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv_requant_pack.md
# conv_requant_pack

Requantization stage directly downstream of `ConvOutput`. It takes 8 lanes of signed 32-bit convolution accumulators per beat, applies a per-output-channel scale, a global right shift, round-half-up and a per-channel bias, and saturates each lane to int8. It packs the 8 results into one 64-bit beat for the write-back DMA and marks the last beat of the layer. Per-channel parameters are streamed in once per layer before any data is accepted.

## Interface
Parameters:
- `LANES`, 8: channels per beat; fixed to 8 in this design.
- `ACC_W`, 32: accumulator width per lane.
- `MAX_CH`, 512: maximum `Out_Channel`; sets parameter RAM depth.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a layer.
- `Out_Channel` in 16: output channels in the layer; must be a multiple of 8. Sampled on `start`.
- `Pixel_Count` in 32: output pixels in the layer. Sampled on `start`.
- `Shift` in 5: global arithmetic right shift, 0..31. Sampled on `start`.
- `pData` in 32: parameter word, laid out as {scale[15:0] unsigned, bias[7:0] signed, 8'h00}.
- `pValid` in 1, `pReady` out 1: parameter stream handshake.
- `sData` in 256: lane i sits at bits [32i+31:32i] and holds channel (group*8+i).
- `sValid` in 1, `sReady` out 1: accumulator stream from `ConvOutput`.
- `mData` out 64: lane i sits at bits [8i+7:8i], int8.
- `mValid` out 1, `mReady` in 1, `mLast` out 1: output stream.
- `busy` out 1: high in LOAD and RUN.
- `done` out 1: one-cycle pulse after the `mLast` handshake.

## Operation
- States are IDLE, LOAD and RUN.
- IDLE to LOAD: on `start` when `Out_Channel` ≠ 0, `Out_Channel`[2:0] = 0 and `Pixel_Count` ≠ 0. Otherwise `start` is ignored.
- `start` is ignored outside IDLE.
- LOAD:
  - `pReady` = 1.
  - Parameter word k (k = 0..`Out_Channel`-1) is written to bank k%8 at address k/8.
  - After word `Out_Channel`-1 is handshaken, the state moves to RUN on the next cycle.
- RUN: beat counters are `grp` (0..`Out_Channel`/8-1) and `pix` (0..`Pixel_Count`-1).
  - Each accepted beat increments `grp`. When `grp` wraps to 0, `pix` increments.
  - The beat with the last `grp` and the last `pix` is tagged last.
- Per-lane arithmetic:
  - prod = acc (signed 32) × {1'b0, scale} (signed 17), giving a signed 49-bit result.
  - r = (prod + (`Shift` ≠ 0 ? 2^(`Shift`-1) : 0)) >>> `Shift`.
  - y = r + sign-extended bias.
  - Output = saturate(y, -128, 127).
- After the last beat is accepted, `sReady` drops. When the last output beat is handshaken, the block pulses `done` and returns to IDLE.
- Parameter RAM is not cleared by reset. Its contents are valid only after a LOAD.

## Timing
- Reset values: `sReady`, `pReady`, `mValid`, `mLast`, `busy` and `done` are 0; `mData` is 64'h0; state is IDLE; all counters are 0.
- Pipeline stages:
  - S0 accepts the beat and does the registered parameter RAM read.
  - S1 multiplies.
  - S2 rounds, adds bias, saturates and drives the output register.
- Latency: an input handshake at cycle t gives `mValid` at t+3 when there is no backpressure.
- Stall: `en` = !`mValid` | `mReady`. All stages hold when `en` = 0.
- `sReady` = (state = RUN) & `en` & !last_accepted. Throughput is 1 beat per cycle.
- `mData` and `mLast` stay stable while `mValid` & !`mReady`.
- `mLast` is high only on the final beat, coincident with its `mValid`.
- `done` is asserted the cycle after the `mLast` handshake; `busy` falls in that same cycle.
- A `start` arriving in the same cycle as the `mLast` handshake is ignored.
- `reset` mid-layer aborts immediately: in-flight beats are dropped and outputs return to their reset values.

## Structure
- Package `conv_requant_pkg` holds `LANES`, `ACC_W`, `PROD_W` = 49, the state enum {IDLE, LOAD, RUN} and an `sat_int8` function.
- Sub-module `requant_lane` implements one lane's S1/S2 datapath (multiply, round, shift, bias, saturate, with enable). It is instantiated `LANES` times.
- The top level holds the FSM, the counters, the 8-bank parameter RAM and the handshake logic.

## Test plan
- Basic: `Out_Channel`=16, `Pixel_Count`=2, `Shift`=8, all scale=256, bias=0, acc=100 in every lane. Expect 4 output beats, every byte 8'h64, `mLast` only on beat 4, `done` one cycle after it.
- Rounding and saturation: `Shift`=4, scale=1, bias=-3.
  - acc=40 gives 8'h00 (40/16 = 2.5, rounds to 3, plus bias -3 = 0).
  - acc=10000 gives 8'h7F.
  - acc=-10000 gives 8'h80.
- Lane/channel mapping: `Out_Channel`=16, scale=1, `Shift`=0, bias = channel index, acc=0. Expect beat 0 = 64'h0706050403020100 and beat 1 = 64'h0F0E0D0C0B0A0908.
- Backpressure: `mReady` toggles 1-0-0-1 pseudo-randomly with `sValid` always high. Expect no loss or duplication; output sequence matches the golden model; `mData` stays stable while stalled.
- Illegal start: `Out_Channel`=12 or `Pixel_Count`=0. Expect `busy` to stay 0 and `pReady` to stay 0.
- Reset mid-RUN, then a new layer: after `reset`, all outputs return to 0, and a full new LOAD/RUN completes correctly with fresh parameters.
